// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame transmitter:
//   DEFAULT_CLK_DIV       default clk cycles per UART bit
//   FRAME_SOF / FRAME_EOF ASCII frame delimiters '<' and '>'
//   tx_state_e            byte-serializer FSM states
//   hex_ascii()           4-bit nibble -> uppercase ASCII hex digit
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int         DEFAULT_CLK_DIV = 54;
   localparam logic [7:0] FRAME_SOF       = 8'h3C;
   localparam logic [7:0] FRAME_EOF       = 8'h3E;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } tx_state_e;

   // 0-9 map to 0x30-0x39, A-F map to 0x41-0x46
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      logic [7:0] c;
      if (nib < 4'd10) begin
         c = 8'h30 + {4'h0, nib};
      end else begin
         c = 8'h37 + {4'h0, nib};
      end
      return c;
   endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// ---------------------------------------------------------------------------
// uart_frame_tx_if
// Request/status bundle of the UART frame transmitter.
//   start    frame request
//   bank     bank number placed in the frame header
//   data_in  payload, most significant byte sent first
//   txd      UART serial line (idle high)
//   busy     frame in progress
//   done     one-cycle pulse at end of frame
// master: requester side, slave: transmitter side.
// ---------------------------------------------------------------------------
interface uart_frame_tx_if #(
   parameter int DATA_BYTES = 32
);
   logic                    start;
   logic [7:0]              bank;
   logic [8*DATA_BYTES-1:0] data_in;
   logic                    txd;
   logic                    busy;
   logic                    done;

   modport master (output start, output bank, output data_in,
                   input  txd,   input  busy, input  done);

   modport slave  (input  start, input  bank, input  data_in,
                   output txd,   output busy, output done);
endinterface

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// 8N1 byte serializer with a load/ready handshake. A byte offered with
// load while ready is high starts on the next cycle. ready is also high in
// the final cycle of a non-last stop bit, so consecutive bytes leave no
// idle gap. A byte flagged 'last' ends in DONE for exactly one cycle.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        byte_in/last valid
//   last        byte being loaded is the final one of the frame
//   byte_in     byte to send
//   ready       a load this cycle is accepted
//   txd         serial output (registered, idle high)
//   busy        START/DATA/STOP in progress (registered)
//   done        one-cycle end-of-frame pulse (registered)
// ---------------------------------------------------------------------------
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       last,
   input  logic [7:0] byte_in,
   output logic       ready,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   localparam int                BAUD_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
   localparam logic [BAUD_W-1:0] BAUD_ZERO   = {BAUD_W{1'b0}};
   localparam logic [BAUD_W-1:0] BAUD_ONE    = BAUD_W'(1);

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q,  baud_d;
   logic [2:0]        bit_q,   bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              last_q,  last_d;
   logic              txd_q,   txd_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
   logic              bit_end_s;

   assign bit_end_s = (baud_q == BAUD_ZERO);
   assign ready     = (state_q == IDLE) || (state_q == DONE) ||
                      ((state_q == STOP) && bit_end_s && !last_q);
   assign txd       = txd_q;
   assign busy      = busy_q;
   assign done      = done_q;

   // Next-state, counter and registered-output computation
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      last_d  = last_q;
      case (state_q)
         IDLE, DONE: begin
            if (load) begin
               state_d = START;
               baud_d  = BAUD_RELOAD;
               bit_d   = 3'd0;
               shift_d = byte_in;
               last_d  = last;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_d = DATA;
               baud_d  = BAUD_RELOAD;
               bit_d   = 3'd0;
            end else begin
               baud_d  = baud_q - BAUD_ONE;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               baud_d = BAUD_RELOAD;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_d = baud_q - BAUD_ONE;
            end
         end
         STOP: begin
            if (bit_end_s) begin
               if (last_q) begin
                  state_d = DONE;
                  last_d  = 1'b0;
               end else if (load) begin
                  // back-to-back: next start bit follows with no gap
                  state_d = START;
                  baud_d  = BAUD_RELOAD;
                  bit_d   = 3'd0;
                  shift_d = byte_in;
                  last_d  = last;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q - BAUD_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = BAUD_ZERO;
            bit_d   = 3'd0;
            last_d  = 1'b0;
         end
      endcase

      // outputs are decoded from the next state so they register cleanly
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
      done_d = (state_d == DONE);
   end

   // Serializer state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= BAUD_ZERO;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         last_q  <= 1'b0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
// Sends "<" + hex(bank) + hex(data_in) + ">" as 8N1 ASCII, nibbles MSB
// first, uppercase hex. bank/data_in are captured when start is accepted;
// further start requests are ignored until the frame finishes.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         uart_frame_tx_if slave: start/bank/data_in in,
//               txd/busy/done out
// ---------------------------------------------------------------------------
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = DEFAULT_CLK_DIV,
   parameter int DATA_BYTES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_frame_tx_if.slave  bus
);

   localparam int               NCHARS   = 4 + 2 * DATA_BYTES;
   localparam int               IDX_W    = $clog2(NCHARS);
   localparam int               PAY_W    = 8 * (DATA_BYTES + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHARS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

   // bank and payload in one shift register: the next hex nibble is always
   // the top nibble
   logic [PAY_W-1:0] payload_q, payload_d;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic             active_q,  active_d;
   logic             load_s;
   logic             last_s;
   logic [7:0]       byte_s;
   logic             ready_s;

   // Character sequencing: pick the next ASCII char whenever the serializer
   // can take one
   always_comb begin
      payload_d = payload_q;
      idx_d     = idx_q;
      active_d  = active_q;
      load_s    = 1'b0;
      last_s    = 1'b0;
      byte_s    = FRAME_SOF;
      if (active_q) begin
         if (ready_s) begin
            load_s = 1'b1;
            if (idx_q == IDX_LAST) begin
               byte_s   = FRAME_EOF;
               last_s   = 1'b1;
               active_d = 1'b0;
               idx_d    = IDX_ZERO;
            end else begin
               byte_s    = hex_ascii(payload_q[PAY_W-1 -: 4]);
               payload_d = {payload_q[PAY_W-5:0], 4'h0};
               idx_d     = idx_q + IDX_ONE;
            end
         end else begin
            load_s = 1'b0;
         end
      end else begin
         // only IDLE/DONE report ready while no frame is being sequenced
         if (bus.start && ready_s) begin
            load_s    = 1'b1;
            byte_s    = FRAME_SOF;
            payload_d = {bus.bank, bus.data_in};
            idx_d     = IDX_ONE;
            active_d  = 1'b1;
         end else begin
            load_s = 1'b0;
         end
      end
   end

   // Frame sequencing registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         payload_q <= {PAY_W{1'b0}};
         idx_q     <= IDX_ZERO;
         active_q  <= 1'b0;
      end else begin
         payload_q <= payload_d;
         idx_q     <= idx_d;
         active_q  <= active_d;
      end
   end

   uart_tx_byte #(
      .CLK_DIV (CLK_DIV)
   ) u_tx_byte (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_s),
      .last    (last_s),
      .byte_in (byte_s),
      .ready   (ready_s),
      .txd     (bus.txd),
      .busy    (bus.busy),
      .done    (bus.done)
   );

endmodule

// File: tb/tb_uart_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_tx
// Two transmitters: dut_a (1 payload byte) and dut_b (32 payload bytes).
// Expected ASCII chars are queued when a frame is requested; a receiver
// process per DUT rebuilds each 8N1 char from txd and pops/compares.
// ---------------------------------------------------------------------------
module tb_uart_frame_tx;

   localparam int DIV    = 54;
   localparam int A_CYC  = 6 * 10 * DIV;
   localparam int B_CYC  = 68 * 10 * DIV;

   logic clk = 1'b0;
   logic rst_n_a;
   logic rst_n_b;

   always #5 clk = ~clk;

   uart_frame_tx_if #(.DATA_BYTES(1)) bus_a ();
   uart_frame_tx_if #(.DATA_BYTES(32)) bus_b ();

   uart_frame_tx #(.CLK_DIV(DIV), .DATA_BYTES(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n_a),
      .bus   (bus_a)
   );

   uart_frame_tx #(.CLK_DIV(DIV), .DATA_BYTES(32)) dut_b (
      .clk   (clk),
      .rst_n (rst_n_b),
      .bus   (bus_b)
   );

   int         pass_cnt = 0;
   int         fail_cnt = 0;
   logic [7:0] exp_q_a[$];
   logic [7:0] exp_q_b[$];
   logic [7:0] rx_frame_a[$];
   string      hexs = "0123456789ABCDEF";

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] hx(input logic [3:0] n);
      return hexs[n];
   endfunction

   function automatic logic [3:0] unhex(input logic [7:0] c);
      if (c >= 8'h41) return c[3:0] + 4'd9;
      else            return c[3:0];
   endfunction

   function automatic logic txd_of(input int sel);
      return (sel == 0) ? bus_a.txd : bus_b.txd;
   endfunction

   function automatic logic rst_of(input int sel);
      return (sel == 0) ? rst_n_a : rst_n_b;
   endfunction

   function automatic logic busy_of(input int sel);
      return (sel == 0) ? bus_a.busy : bus_b.busy;
   endfunction

   function automatic logic done_of(input int sel);
      return (sel == 0) ? bus_a.done : bus_b.done;
   endfunction

   task automatic push_frame(input int sel, input logic [7:0] bk,
                             input logic [255:0] d, input int nbytes);
      logic [7:0] c[$];
      c.push_back(8'h3C);
      c.push_back(hx(bk[7:4]));
      c.push_back(hx(bk[3:0]));
      for (int i = 2 * nbytes - 1; i >= 0; i--) c.push_back(hx(d[4*i +: 4]));
      c.push_back(8'h3E);
      foreach (c[k]) begin
         if (sel == 0) exp_q_a.push_back(c[k]);
         else          exp_q_b.push_back(c[k]);
      end
   endtask

   // 8N1 receiver: every cycle of every bit is sampled so a wrong bit
   // length shows up as an unstable bit or a shifted char
   task automatic rx_loop(input int sel);
      logic [9:0] bits;
      logic       first_s;
      bit         stable;
      bit         aborted;
      logic [8:0] expv;
      logic [7:0] ch;
      first_s = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_of(sel) && !txd_of(sel)) begin
            stable  = 1'b1;
            aborted = 1'b0;
            bits    = 10'h000;
            for (int b = 0; b < 10 && !aborted; b++) begin
               for (int c = 0; c < DIV && !aborted; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (!rst_of(sel))                 aborted = 1'b1;
                  else if (c == 0)                  first_s = txd_of(sel);
                  else if (txd_of(sel) !== first_s) stable  = 1'b0;
               end
               bits[b] = first_s;
            end
            if (!aborted) begin
               ch = bits[8:1];
               chk("rx_stop_bit", {63'd0, bits[9]}, 64'd1);
               chk("rx_bit_width", {63'd0, stable}, 64'd1);
               if (sel == 0) begin
                  expv = (exp_q_a.size() > 0) ? {1'b0, exp_q_a.pop_front()} : 9'h100;
                  rx_frame_a.push_back(ch);
                  chk("rx_char_a", {55'd0, 1'b0, ch}, {55'd0, expv});
               end else begin
                  expv = (exp_q_b.size() > 0) ? {1'b0, exp_q_b.pop_front()} : 9'h100;
                  chk("rx_char_b", {55'd0, 1'b0, ch}, {55'd0, expv});
               end
            end
         end
      end
   endtask

   initial rx_loop(0);
   initial rx_loop(1);

   // called on a negedge; returns on the negedge where done is seen
   task automatic wait_done(input int sel, input int limit,
                            output int busy_cnt, output bit seen);
      busy_cnt = 0;
      seen     = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (done_of(sel)) begin
            seen = 1'b1;
            break;
         end
         if (busy_of(sel)) busy_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic start_a(input logic [7:0] bk, input logic [7:0] d);
      bus_a.bank    = bk;
      bus_a.data_in = d;
      bus_a.start   = 1'b1;
      push_frame(0, bk, {248'd0, d}, 1);
      @(negedge clk);
      bus_a.start = 1'b0;
      chk("accept_busy", {63'd0, bus_a.busy}, 64'd1);
      chk("accept_start_bit", {63'd0, bus_a.txd}, 64'd0);
   endtask

   int   bc;
   bit   seen;
   bit   any_busy;
   bit   any_done;
   logic [7:0] rx_bank;
   logic [7:0] rx_data;

   initial begin
      rst_n_a       = 1'b0;
      rst_n_b       = 1'b0;
      bus_a.start   = 1'b0;
      bus_a.bank    = 8'h00;
      bus_a.data_in = 8'h00;
      bus_b.start   = 1'b0;
      bus_b.bank    = 8'h00;
      bus_b.data_in = {256{1'b0}};
      repeat (3) @(negedge clk);
      chk("rst_txd_a",  {63'd0, bus_a.txd},  64'd1);
      chk("rst_busy_a", {63'd0, bus_a.busy}, 64'd0);
      chk("rst_done_a", {63'd0, bus_a.done}, 64'd0);
      chk("rst_txd_b",  {63'd0, bus_b.txd},  64'd1);
      chk("rst_busy_b", {63'd0, bus_b.busy}, 64'd0);
      chk("rst_done_b", {63'd0, bus_b.done}, 64'd0);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      repeat (2) @(negedge clk);

      // A: "<0120>"
      start_a(8'h01, 8'h20);
      wait_done(0, A_CYC + 100, bc, seen);
      chk("A_done_seen", {63'd0, seen}, 64'd1);
      chk("A_busy_cycles", 64'(bc), 64'(A_CYC));
      chk("A_busy_low_at_done", {63'd0, bus_a.busy}, 64'd0);
      chk("A_sb_drained", 64'(exp_q_a.size()), 64'd0);
      @(negedge clk);
      chk("A_done_one_cycle", {63'd0, bus_a.done}, 64'd0);
      repeat (3) @(negedge clk);

      // C: decode the looped-back frame
      rx_frame_a.delete();
      start_a(8'h01, 8'hC7);
      wait_done(0, A_CYC + 100, bc, seen);
      chk("C_done_seen", {63'd0, seen}, 64'd1);
      chk("C_len", 64'(rx_frame_a.size()), 64'd6);
      if (rx_frame_a.size() == 6) begin
         rx_bank = {unhex(rx_frame_a[1]), unhex(rx_frame_a[2])};
         rx_data = {unhex(rx_frame_a[3]), unhex(rx_frame_a[4])};
         chk("C_bank", {56'd0, rx_bank}, 64'h01);
         chk("C_data", {56'd0, rx_data}, 64'hC7);
      end
      repeat (3) @(negedge clk);

      // D: second start and new data mid-frame are ignored
      start_a(8'h5A, 8'h3B);
      repeat (499) @(negedge clk);
      bus_a.start   = 1'b1;
      bus_a.bank    = 8'h99;
      bus_a.data_in = 8'h44;
      @(negedge clk);
      bus_a.start = 1'b0;
      wait_done(0, A_CYC, bc, seen);
      chk("D_done_seen", {63'd0, seen}, 64'd1);
      chk("D_sb_drained", 64'(exp_q_a.size()), 64'd0);
      any_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         any_busy = any_busy | bus_a.busy;
      end
      chk("D_no_queued_frame", {63'd0, any_busy}, 64'd0);

      // E: reset during char 3
      start_a(8'hE3, 8'h6D);
      repeat (2 * 10 * DIV + 200) @(negedge clk);
      #2 rst_n_a = 1'b0;
      #1;
      chk("E_txd_async", {63'd0, bus_a.txd}, 64'd1);
      chk("E_busy_async", {63'd0, bus_a.busy}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("E_txd_in_reset", {63'd0, bus_a.txd}, 64'd1);
         chk("E_done_in_reset", {63'd0, bus_a.done}, 64'd0);
      end
      rst_n_a = 1'b1;
      exp_q_a.delete();
      any_busy = 1'b0;
      any_done = 1'b0;
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         any_busy = any_busy | bus_a.busy;
         any_done = any_done | bus_a.done;
      end
      chk("E_no_done_after_abort", {63'd0, any_done}, 64'd0);
      chk("E_idle_after_abort", {63'd0, any_busy}, 64'd0);
      start_a(8'h4B, 8'hA0);
      wait_done(0, A_CYC + 100, bc, seen);
      chk("E_new_frame_done", {63'd0, seen}, 64'd1);
      chk("E_new_frame_cycles", 64'(bc), 64'(A_CYC));
      chk("E_sb_drained", 64'(exp_q_a.size()), 64'd0);
      repeat (3) @(negedge clk);

      // F: start held high -> back-to-back frames, one idle cycle apart
      bus_a.bank    = 8'h7E;
      bus_a.data_in = 8'h09;
      bus_a.start   = 1'b1;
      push_frame(0, 8'h7E, {248'd0, 8'h09}, 1);
      @(negedge clk);
      chk("F_accept_busy", {63'd0, bus_a.busy}, 64'd1);
      for (int f = 0; f < 3; f++) begin
         wait_done(0, A_CYC + 100, bc, seen);
         chk("F_done_seen", {63'd0, seen}, 64'd1);
         chk("F_busy_cycles", 64'(bc), 64'(A_CYC));
         chk("F_gap_txd_high", {63'd0, bus_a.txd}, 64'd1);
         chk("F_gap_busy_low", {63'd0, bus_a.busy}, 64'd0);
         chk("F_sb_drained", 64'(exp_q_a.size()), 64'd0);
         if (f < 2) push_frame(0, 8'h7E, {248'd0, 8'h09}, 1);
         @(negedge clk);
         if (f < 2) begin
            chk("F_restart_busy", {63'd0, bus_a.busy}, 64'd1);
            chk("F_restart_start_bit", {63'd0, bus_a.txd}, 64'd0);
            chk("F_done_single", {63'd0, bus_a.done}, 64'd0);
            if (f == 1) bus_a.start = 1'b0;
         end else begin
            chk("F_stop_busy", {63'd0, bus_a.busy}, 64'd0);
            chk("F_stop_done", {63'd0, bus_a.done}, 64'd0);
         end
      end

      // B: default size, "<AF" + 64 x 'F' + ">"
      bus_b.bank    = 8'hAF;
      bus_b.data_in = {32{8'hFF}};
      bus_b.start   = 1'b1;
      push_frame(1, 8'hAF, {32{8'hFF}}, 32);
      @(negedge clk);
      bus_b.start = 1'b0;
      chk("B_accept_busy", {63'd0, bus_b.busy}, 64'd1);
      chk("B_queued_chars", 64'(exp_q_b.size()), 64'd68);
      wait_done(1, B_CYC + 100, bc, seen);
      chk("B_done_seen", {63'd0, seen}, 64'd1);
      chk("B_busy_cycles", 64'(bc), 64'(B_CYC));
      chk("B_sb_drained", 64'(exp_q_b.size()), 64'd0);
      @(negedge clk);
      chk("B_done_one_cycle", {63'd0, bus_b.done}, 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
      $finish;
   end

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter CLK_DIV, default 54, SHALL set clk cycles per UART bit (50 MHz clk, about 926 kbaud, bit time 1.08 us).
REQ-002 Parameter DATA_BYTES, default 32, SHALL set payload bytes per frame (256-bit payload).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  frame request; sampled only in IDLE.
REQ-006 bank  input  8  bank number sent in the frame header.
REQ-007 data_in  input  8*DATA_BYTES  payload; byte DATA_BYTES-1 is sent first.
REQ-008 txd  output  1  UART serial line; idle high.
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  single-cycle pulse after the last stop bit of the frame.

Function
REQ-011 Frame SHALL be ASCII: '<' (0x3C), 2 hex chars of bank, 2*DATA_BYTES hex chars of data_in, '>' (0x3E); hex chars MSB nibble first.
REQ-012 Hex digits SHALL be uppercase: 0-9 as 0x30-0x39, A-F as 0x41-0x46.
REQ-013 Total chars per frame SHALL be 4+2*DATA_BYTES (68 at default).
REQ-014 Each char SHALL be sent 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-015 Each bit SHALL last exactly CLK_DIV cycles; chars SHALL be sent back-to-back with no idle gap.
REQ-016 Frame duration SHALL be (4+2*DATA_BYTES)*10*CLK_DIV cycles, from the first start-bit edge to the end of the last stop bit.
REQ-017 If start=1 in IDLE, bank and data_in SHALL be latched on that edge, and busy and the txd start bit SHALL assert on the next cycle.
REQ-018 Input changes after the latch SHALL NOT affect the frame in progress.
REQ-019 start while busy=1 SHALL be ignored, with no queuing.
REQ-020 done SHALL pulse for 1 cycle in the cycle after the final stop bit ends, with busy falling in that same cycle.
REQ-021 start=1 in the done cycle SHALL be accepted, giving back-to-back frames separated by one idle-high cycle.
REQ-022 The FSM SHALL have states IDLE, START, DATA, STOP and DONE.
  - IDLE->START on start.
  - START->DATA after CLK_DIV cycles.
  - DATA->STOP after 8 bits.
  - STOP->START when more chars remain; STOP->DONE after the last char.
  - DONE->IDLE, or DONE->START if start is accepted per REQ-021.
REQ-023 The char index counter SHALL be sized with $clog2(4+2*DATA_BYTES) bits and SHALL NOT wrap within a frame.
REQ-024 The baud counter SHALL count CLK_DIV-1 down to 0 and SHALL reload at each bit boundary.
REQ-025 txd SHALL be driven from a register, not combinationally.

Reset
REQ-026 While rst_n=0: txd=1, busy=0, done=0, FSM=IDLE, all counters 0 and latched registers 0.
REQ-027 rst_n falling mid-frame SHALL force txd=1 immediately (asynchronous); the frame is aborted and no done pulse is produced.
REQ-028 After rst_n rises, the first accepted start SHALL begin a complete new frame.

Structure
REQ-029 A shared package uart_pkg SHALL hold the ASCII constants FRAME_SOF=0x3C and FRAME_EOF=0x3E, the FSM state enumeration, and the default CLK_DIV.
REQ-030 Byte serialization (baud counter, shift register, START/DATA/STOP timing) SHALL be a sub-module uart_tx_byte with a load/ready handshake.
REQ-031 uart_frame_tx SHALL own char sequencing and hex encoding.

Verification
REQ-032 Scenario A, DATA_BYTES=1, CLK_DIV=54: start with bank=0x01, data_in=0x20 -> txd carries "<0120>" = 0x3C 0x30 0x31 0x32 0x30 0x3E in 3240 cycles, then a done pulse.
REQ-033 Scenario B, default params: bank=0xAF, data_in=all 0xFF -> "<AF", 64x 'F' (0x46), ">"; 68 chars; busy high for 36720 cycles.
REQ-034 Scenario C: bench-check the bit width on txd with a loopback into the team's UART receiver -> receiver data_out equals data_in and bank equals 0x01.
REQ-035 Scenario D: second start pulse 500 cycles into a frame, and data_in changed -> ignored; the transmitted frame matches the originally latched values.
REQ-036 Scenario E: rst_n low for 3 cycles during char 3 -> txd=1 within the reset, busy=0, no done; a new start sends a full correct frame.
REQ-037 Scenario F: start held high continuously -> consecutive frames each separated by exactly 1 idle-high cycle, with one done pulse per frame.
